// File: rtl/pp_accum_if.sv
// Handshake bundle between the partial-product generator, the accumulation
// sequencer and the final-product stage.
interface pp_accum_if #(
    parameter int ACC_W = 61,
    parameter int PP_W  = 48,
    parameter int CNT_W = 6
);
    logic             start;
    logic [CNT_W-1:0] num_terms;
    logic             busy;
    logic             pp_valid;
    logic [PP_W-1:0]  pp_data;
    logic             pp_ready;
    logic             res_valid;
    logic [ACC_W-1:0] res_data;
    logic             res_overflow;
    logic             res_ready;

    // master: the side that issues jobs, supplies terms and takes results
    modport master (
        output start, num_terms, pp_valid, pp_data, res_ready,
        input  busy, pp_ready, res_valid, res_data, res_overflow
    );

    modport slave (
        input  start, num_terms, pp_valid, pp_data, res_ready,
        output busy, pp_ready, res_valid, res_data, res_overflow
    );
endinterface

// File: rtl/pp_accum_sequencer.sv
// Drives the shared accumulation adder so a stream of partial products is
// summed into a wide running total, with a sticky carry-out flag per job.

// Wide + narrow adder; B is zero-extended and the top Sum bit is the carry-out.
module customAdder61_13 #(
    parameter int A_W = 61,
    parameter int B_W = 48
) (
    input  logic [A_W-1:0] A,
    input  logic [B_W-1:0] B,
    output logic [A_W:0]   Sum
);
    assign Sum = {1'b0, A} + {{(A_W + 1 - B_W){1'b0}}, B};
endmodule

module pp_accum_sequencer #(
    parameter int ACC_W = 61,
    parameter int PP_W  = 48,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       reset,
    pp_accum_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] remaining_q;
    logic             ovf_q;
    logic             busy_q;
    logic             pp_ready_q;
    logic             res_valid_q;
    logic [ACC_W:0]   sum_d;
    logic             accept_d;
    logic             last_term_d;

    customAdder61_13 #(
        .A_W (ACC_W),
        .B_W (PP_W)
    ) u_adder (
        .A   (acc_q),
        .B   (bus.pp_data),
        .Sum (sum_d)
    );

    // pp_ready_q is high exactly in ACCUM, so acceptance needs no state compare
    assign accept_d    = bus.pp_valid & pp_ready_q;
    assign last_term_d = (remaining_q == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            remaining_q <= '0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            pp_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        acc_q  <= '0;
                        ovf_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (bus.num_terms != '0) begin
                            remaining_q <= bus.num_terms;
                            pp_ready_q  <= 1'b1;
                            state_q     <= ACCUM;
                        end else begin
                            res_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                ACCUM: begin
                    if (accept_d) begin
                        acc_q       <= sum_d[ACC_W-1:0];
                        ovf_q       <= ovf_q | sum_d[ACC_W];
                        remaining_q <= remaining_q - CNT_W'(1);
                        if (last_term_d) begin
                            pp_ready_q  <= 1'b0;
                            res_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    // start is not looked at here; it is only honoured from IDLE
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    pp_ready_q  <= 1'b0;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.pp_ready     = pp_ready_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_data     = acc_q;
    assign bus.res_overflow = ovf_q;
endmodule

// File: tb/tb_pp_accum_sequencer.sv
// Directed scoreboard bench: a full-width instance for the main datapath and
// a narrow instance where accumulator wrap and carry-out are reachable.
module tb_pp_accum_sequencer;
    logic clk;
    logic reset;
    int   cyc;
    int   tests;
    int   fails;
    int   n_push;
    int   n_res;

    typedef struct packed { logic [60:0] data; logic ovf; } exp_t;
    typedef struct packed { logic [9:0]  data; logic ovf; } sexp_t;

    exp_t  exp_q[$];
    sexp_t sexp_q[$];
    exp_t  mon_e;
    sexp_t smon_e;

    pp_accum_if #(.ACC_W(61), .PP_W(48), .CNT_W(6)) bus ();
    pp_accum_if #(.ACC_W(10), .PP_W(8),  .CNT_W(4)) sbus ();

    pp_accum_sequencer #(.ACC_W(61), .PP_W(48), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    pp_accum_sequencer #(.ACC_W(10), .PP_W(8), .CNT_W(4)) sdut (
        .clk   (clk),
        .reset (reset),
        .bus   (sbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: pop one expectation per result handshake
    always @(negedge clk) begin
        if (!reset && bus.res_valid && bus.res_ready) begin
            n_res++;
            if (exp_q.size() == 0) begin
                check("big unexpected result", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("big res_data", 64'(bus.res_data), 64'(mon_e.data));
                check("big res_overflow", 64'(bus.res_overflow), 64'(mon_e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && sbus.res_valid && sbus.res_ready) begin
            if (sexp_q.size() == 0) begin
                check("small unexpected result", 64'd1, 64'd0);
            end else begin
                smon_e = sexp_q.pop_front();
                check("small res_data", 64'(sbus.res_data), 64'(smon_e.data));
                check("small res_overflow", 64'(sbus.res_overflow), 64'(smon_e.ovf));
            end
        end
    end

    task automatic push_exp(input logic [60:0] d, input logic o);
        exp_q.push_back('{data: d, ovf: o});
        n_push++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_job(input logic [5:0] n, output int c0);
        bus.start     = 1'b1;
        bus.num_terms = n;
        c0            = cyc;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic send_terms(input logic [47:0] t[$], input int gap);
        int   i     = 0;
        int   guard = 0;
        logic acc;
        while (i < t.size() && guard < 200) begin
            bus.pp_valid = 1'b1;
            bus.pp_data  = t[i];
            @(negedge clk);
            acc = bus.pp_ready;
            @(posedge clk);
            #1;
            guard++;
            if (acc) begin
                i++;
                bus.pp_valid = 1'b0;
                if (i < t.size()) idle(gap);
            end
        end
        bus.pp_valid = 1'b0;
        if (guard >= 200) check("big term handshake timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_res(input string name, output int cyc_at, output int prdy_seen);
        int g = 0;
        prdy_seen = 0;
        @(negedge clk);
        while (!bus.res_valid && g < 50) begin
            if (bus.pp_ready) prdy_seen++;
            @(negedge clk);
            g++;
        end
        if (g >= 50) check({name, " result timeout"}, 64'd0, 64'd1);
        cyc_at = cyc;
    endtask

    task automatic s_job(input logic [3:0] n, input logic [7:0] t[$]);
        int   i = 0;
        int   g = 0;
        logic a;
        sbus.start     = 1'b1;
        sbus.num_terms = n;
        @(posedge clk);
        #1;
        sbus.start = 1'b0;
        while (i < t.size() && g < 100) begin
            sbus.pp_valid = 1'b1;
            sbus.pp_data  = t[i];
            @(negedge clk);
            a = sbus.pp_ready;
            @(posedge clk);
            #1;
            g++;
            if (a) i++;
        end
        sbus.pp_valid = 1'b0;
        g = 0;
        while (!sbus.res_valid && g < 50) begin
            idle(1);
            g++;
        end
        if (g >= 50) check("small result timeout", 64'd0, 64'd1);
        idle(2);
    endtask

    initial begin
        logic [47:0] tq[$];
        logic [7:0]  sq[$];
        int          c0;
        int          cr;
        int          pr;
        int          bad;

        tests = 0; fails = 0; n_push = 0; n_res = 0; cyc = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.num_terms = '0; bus.pp_valid = 1'b0;
        bus.pp_data = '0; bus.res_ready = 1'b0;
        sbus.start = 1'b0; sbus.num_terms = '0; sbus.pp_valid = 1'b0;
        sbus.pp_data = '0; sbus.res_ready = 1'b1;
        idle(3);
        @(negedge clk);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset pp_ready", 64'(bus.pp_ready), 64'd0);
        check("reset res_valid", 64'(bus.res_valid), 64'd0);
        check("reset res_data", 64'(bus.res_data), 64'd0);
        check("reset res_overflow", 64'(bus.res_overflow), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);

        // Narrow instance: wrap with carry, flag clears on next job, flag is sticky
        sexp_q.push_back('{data: 10'd251, ovf: 1'b1});
        sq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        s_job(4'd5, sq);
        sexp_q.push_back('{data: 10'd3, ovf: 1'b0});
        sq = '{8'd1, 8'd2};
        s_job(4'd2, sq);
        sexp_q.push_back('{data: 10'd252, ovf: 1'b1});
        sq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
        s_job(4'd6, sq);
        check("small results drained", 64'(sexp_q.size()), 64'd0);

        // Three terms, no stalls
        bus.res_ready = 1'b1;
        push_exp(61'h1_0000_0000_000B, 1'b0);
        start_job(6'd3, c0);
        tq = '{48'd5, 48'd7, 48'hFFFF_FFFF_FFFF};
        send_terms(tq, 0);
        wait_res("three-term", cr, pr);
        check("three-term latency", 64'(cr - c0), 64'd4);
        idle(2);

        // Empty job
        push_exp(61'd0, 1'b0);
        start_job(6'd0, c0);
        wait_res("empty", cr, pr);
        check("empty latency", 64'(cr - c0), 64'd1);
        check("empty pp_ready", 64'(pr + int'(bus.pp_ready)), 64'd0);
        idle(2);

        // Input gaps plus result backpressure
        bus.res_ready = 1'b0;
        push_exp(61'd7, 1'b0);
        start_job(6'd2, c0);
        tq = '{48'd3, 48'd4};
        send_terms(tq, 2);
        wait_res("backpressure", cr, pr);
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (!(bus.res_valid && bus.res_data == 61'd7 && !bus.res_overflow && bus.busy)) bad++;
        end
        check("backpressure hold", 64'(bad), 64'd0);
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        @(negedge clk);
        check("after accept busy", 64'(bus.busy), 64'd0);
        check("after accept res_valid", 64'(bus.res_valid), 64'd0);
        idle(1);

        // Reset mid-job discards the partial sum
        bus.res_ready = 1'b1;
        start_job(6'd4, c0);
        tq = '{48'd100};
        send_terms(tq, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort pp_ready", 64'(bus.pp_ready), 64'd0);
        check("abort res_valid", 64'(bus.res_valid), 64'd0);
        check("abort res_data", 64'(bus.res_data), 64'd0);
        idle(1);
        push_exp(61'd9, 1'b0);
        start_job(6'd1, c0);
        tq = '{48'd9};
        send_terms(tq, 0);
        wait_res("post-abort", cr, pr);
        idle(2);

        // start and num_terms wiggled while busy
        bus.res_ready = 1'b0;
        push_exp(61'd30, 1'b0);
        start_job(6'd2, c0);
        bus.start     = 1'b1;
        bus.num_terms = 6'd7;
        tq = '{48'd10, 48'd20};
        send_terms(tq, 0);
        idle(2);
        check("busy-start still done", 64'(bus.res_valid), 64'd1);
        bus.start     = 1'b0;
        bus.res_ready = 1'b1;
        idle(1);
        bus.res_ready = 1'b0;
        idle(4);
        check("busy-start idle", 64'(bus.busy), 64'd0);
        check("big results drained", 64'(exp_q.size()), 64'd0);
        check("one result per job", 64'(n_res), 64'(n_push));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
